// File: rtl/riscv_multi_hs.sv
// riscv_multi_hs: multicycle RV32 integer core with valid/ready instruction
// and data memory ports, so the memories may take any number of cycles.
// Optional feature macro: RV_MUL_EN adds mul (low 32 bits of the product).
module riscv_multi_hs #(
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int          IADDR_W  = 10,
   parameter int          DADDR_W  = 14,
   parameter logic [31:0] EOF_WORD = 32'hFFFF_FFFF
) (
   input  logic               CLOCK_50,
   input  logic               rst,
   output logic               imem_req,
   output logic [IADDR_W-1:0] imem_addr,
   input  logic               imem_rvalid,
   input  logic [31:0]        imem_rdata,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic [DADDR_W-1:0] dmem_addr,
   output logic [31:0]        dmem_wdata,
   input  logic               dmem_ack,
   input  logic [31:0]        dmem_rdata,
   output logic               done,
   output logic               illegal,
   output logic [31:0]        clock_count,
   output logic [31:0]        instr_cnt
);

   typedef enum logic [2:0] {FETCH, FWAIT, DECODE, EXEC, MEM, WB, HALT} state_t;
   typedef enum logic [2:0] {K_ALU, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_JALR, K_BAD} kind_t;

   state_t      state;
   kind_t       kind;
   logic [31:0] regs [0:31];
   logic [31:0] pc, ir, a, b, imm, alu_out, mdr;
   logic        wb_mem;
   logic [31:0] imm_dec, alu_res, old_pc;
   logic        taken;

   logic [6:0] opcode, f7;
   logic [4:0] rd, rs1, rs2;
   logic [2:0] f3;

   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign f3     = ir[14:12];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];
   assign f7     = ir[31:25];
   assign old_pc = pc - 32'd4;   // PC already advanced past this instruction

   assign imem_addr = IADDR_W'(pc >> 2);

   // Immediate extraction for I/S/B/U/J formats, sign-extended
   always_comb begin
      imm_dec = '0;
      case (opcode)
         7'b0010011, 7'b0000011, 7'b1100111: imm_dec = {{20{ir[31]}}, ir[31:20]};
         7'b0100011: imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         7'b1100011: imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         7'b0110111, 7'b0010111: imm_dec = {ir[31:12], 12'b0};
         7'b1101111: imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         default: imm_dec = '0;
      endcase
   end

   // Instruction classification and ALU; anything not listed falls to K_BAD
   always_comb begin
      kind    = K_BAD;
      alu_res = '0;
      taken   = 1'b0;
      case (opcode)
         7'b0110011: begin
            kind = K_ALU;
            case ({f7, f3})
               {7'h00, 3'b000}: alu_res = a + b;
               {7'h20, 3'b000}: alu_res = a - b;
               {7'h00, 3'b001}: alu_res = a << b[4:0];
               {7'h00, 3'b010}: alu_res = {31'b0, $signed(a) < $signed(b)};
               {7'h00, 3'b100}: alu_res = a ^ b;
               {7'h00, 3'b101}: alu_res = a >> b[4:0];
               {7'h20, 3'b101}: alu_res = $signed(a) >>> b[4:0];
               {7'h00, 3'b110}: alu_res = a | b;
               {7'h00, 3'b111}: alu_res = a & b;
`ifdef RV_MUL_EN
               {7'h01, 3'b000}: alu_res = a * b;
`endif
               default: kind = K_BAD;
            endcase
         end
         7'b0010011: begin
            kind = K_ALU;
            case (f3)
               3'b000: alu_res = a + imm;
               3'b010: alu_res = {31'b0, $signed(a) < $signed(imm)};
               3'b110: alu_res = a | imm;
               3'b111: alu_res = a & imm;
               default: kind = K_BAD;
            endcase
         end
         7'b0000011: if (f3 == 3'b010) kind = K_LOAD;
         7'b0100011: if (f3 == 3'b010) kind = K_STORE;
         7'b1100011: begin
            kind = K_BRANCH;
            case (f3)
               3'b000: taken = (a == b);
               3'b001: taken = (a != b);
               3'b100: taken = ($signed(a) <  $signed(b));
               3'b101: taken = ($signed(a) >= $signed(b));
               default: kind = K_BAD;
            endcase
         end
         7'b1101111: kind = K_JAL;
         7'b1100111: if (f3 == 3'b000) kind = K_JALR;
         7'b0110111: begin kind = K_ALU; alu_res = imm; end
         7'b0010111: begin kind = K_ALU; alu_res = old_pc + imm; end
         default: kind = K_BAD;
      endcase
   end

   // Core sequencer: fetch/decode/execute/memory/writeback with handshakes
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         clock_count <= '0;
         instr_cnt   <= '0;
         done        <= 1'b0;
         illegal     <= 1'b0;
         imem_req    <= 1'b0;
         dmem_req    <= 1'b0;
         dmem_we     <= 1'b0;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         if (state != HALT) clock_count <= clock_count + 32'd1;
         case (state)
            FETCH: begin
               imem_req <= 1'b1;
               state    <= FWAIT;
            end
            FWAIT: if (imem_rvalid) begin
               ir       <= imem_rdata;
               pc       <= pc + 32'd4;
               imem_req <= 1'b0;
               state    <= DECODE;
            end
            DECODE: begin
               if (ir == EOF_WORD) begin
                  done  <= 1'b1;
                  state <= HALT;
               end else begin
                  a     <= regs[rs1];
                  b     <= regs[rs2];
                  imm   <= imm_dec;
                  state <= EXEC;
               end
            end
            EXEC: begin
               case (kind)
                  K_ALU: begin
                     alu_out <= alu_res;
                     wb_mem  <= 1'b0;
                     state   <= WB;
                  end
                  K_LOAD, K_STORE: begin
                     dmem_req   <= 1'b1;
                     dmem_we    <= (kind == K_STORE);
                     dmem_addr  <= DADDR_W'((a + imm) >> 2);
                     dmem_wdata <= b;
                     state      <= MEM;
                  end
                  K_BRANCH: begin
                     if (taken) pc <= old_pc + imm;
                     instr_cnt <= instr_cnt + 32'd1;
                     state     <= FETCH;
                  end
                  K_JAL: begin
                     if (rd != 5'd0) regs[rd] <= pc;
                     pc        <= old_pc + imm;
                     instr_cnt <= instr_cnt + 32'd1;
                     state     <= FETCH;
                  end
                  K_JALR: begin
                     if (rd != 5'd0) regs[rd] <= pc;
                     pc        <= (a + imm) & ~32'd1;
                     instr_cnt <= instr_cnt + 32'd1;
                     state     <= FETCH;
                  end
                  default: begin
                     done    <= 1'b1;
                     illegal <= 1'b1;
                     state   <= HALT;
                  end
               endcase
            end
            MEM: if (dmem_ack) begin
               dmem_req <= 1'b0;
               dmem_we  <= 1'b0;
               if (dmem_we) begin
                  instr_cnt <= instr_cnt + 32'd1;
                  state     <= FETCH;
               end else begin
                  mdr    <= dmem_rdata;
                  wb_mem <= 1'b1;
                  state  <= WB;
               end
            end
            WB: begin
               if (rd != 5'd0) regs[rd] <= wb_mem ? mdr : alu_out;
               instr_cnt <= instr_cnt + 32'd1;
               state     <= FETCH;
            end
            default: ;   // HALT is terminal until reset
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_multi_hs.sv
// Directed testbench for riscv_multi_hs with latency-programmable memories.
module tb_riscv_multi_hs;

   localparam logic [31:0] EOF = 32'hFFFF_FFFF;
   localparam logic [6:0]  OPI = 7'b0010011;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req, imem_rvalid;
   logic [9:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [13:0] dmem_addr;
   logic [31:0] dmem_wdata, dmem_rdata;
   logic        done, illegal;
   logic [31:0] clock_count, instr_cnt;

   always #5 clk = ~clk;

   riscv_multi_hs dut (
      .CLOCK_50(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .done(done), .illegal(illegal), .clock_count(clock_count), .instr_cnt(instr_cnt)
   );

   // memory models
   logic [31:0] imem [0:1023];
   logic [31:0] dmem [0:16383];
   int          imem_lat, dmem_lat, icnt, dcnt;
   logic        force_rv;
   logic [31:0] force_data;

   assign imem_rvalid = force_rv | (imem_req && icnt >= imem_lat);
   assign imem_rdata  = force_rv ? force_data : imem[imem_addr];
   assign dmem_ack    = dmem_req && dcnt >= dmem_lat;
   assign dmem_rdata  = dmem[dmem_addr];

   always @(posedge clk) begin
      icnt <= (rst || !imem_req || imem_rvalid) ? 0 : icnt + 1;
      dcnt <= (rst || !dmem_req || dmem_ack) ? 0 : dcnt + 1;
      if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr] <= dmem_wdata;
   end

   // monitors: fetched addresses and completed data transactions
   typedef struct {logic [13:0] addr; logic we; logic [31:0] wdata; int held;} drec_t;
   logic [9:0] fq [$];
   drec_t      dq [$];
   int         hcnt, drop_err;
   logic       prev_pend;

   always @(negedge clk) begin
      if (rst) begin
         hcnt <= 0; drop_err <= 0; prev_pend <= 1'b0;
      end else begin
         if (imem_req && imem_rvalid && !force_rv) fq.push_back(imem_addr);
         if (dmem_req && dmem_ack) begin
            dq.push_back('{dmem_addr, dmem_we, dmem_wdata, hcnt + 1});
            hcnt <= 0;
         end else if (dmem_req) hcnt <= hcnt + 1;
         if (prev_pend && !dmem_req) drop_err <= drop_err + 1;
         prev_pend <= dmem_req && !dmem_ack;
      end
   end

   int n_cmp = 0, n_bad = 0;

   // tiny assembler; branch/jump offsets are passed already divided by 2
   function automatic logic [31:0] i_t(logic [11:0] im, logic [4:0] r1, logic [2:0] f3, logic [4:0] d, logic [6:0] op);
      return {im, r1, f3, d, op};
   endfunction
   function automatic logic [31:0] r_t(logic [6:0] f7, logic [4:0] r2, logic [4:0] r1, logic [2:0] f3, logic [4:0] d);
      return {f7, r2, r1, f3, d, 7'b0110011};
   endfunction
   function automatic logic [31:0] s_t(logic [11:0] im, logic [4:0] r2, logic [4:0] r1);
      return {im[11:5], r2, r1, 3'b010, im[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] b_t(logic [2:0] f3, logic [4:0] r1, logic [4:0] r2, logic [11:0] o);
      return {o[11], o[9:4], r2, r1, f3, o[3:0], o[10], 7'b1100011};
   endfunction
   function automatic logic [31:0] j_t(logic [4:0] d, logic [19:0] o);
      return {o[19], o[9:0], o[10], o[18:11], d, 7'b1101111};
   endfunction
   function automatic logic [31:0] u_t(logic [6:0] op, logic [4:0] d, logic [19:0] up);
      return {up, d, op};
   endfunction

   task automatic clear_imem();
      for (int i = 0; i < 1024; i++) imem[i] = EOF;
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1; force_rv = 1'b0;
      @(negedge clk);
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      bit ok;
      clear_imem();
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset.done got %b want 0", done); end
      n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL reset.illegal got %b want 0", illegal); end
      n_cmp++; if ({imem_req, dmem_req, dmem_we} !== 3'b000) begin n_bad++; $display("FAIL reset.req got %b want 000", {imem_req, dmem_req, dmem_we}); end
      n_cmp++; if (clock_count !== 32'd0) begin n_bad++; $display("FAIL reset.clock_count got %0d want 0", clock_count); end
      n_cmp++; if (instr_cnt !== 32'd0) begin n_bad++; $display("FAIL reset.instr_cnt got %0d want 0", instr_cnt); end
      @(negedge clk); rst = 1'b0;
      wait_done(50, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL reset.eof timeout got done=0 want 1"); end
      n_cmp++; if (clock_count !== 32'd3) begin n_bad++; $display("FAIL reset.eof_cycles got %0d want 3", clock_count); end
   endtask

   task automatic test_alu_basic();
      bit ok;
      clear_imem();
      imem[0] = i_t(12'd5, 5'd0, 3'b000, 5'd1, OPI);
      imem[1] = i_t(12'hFFD, 5'd0, 3'b000, 5'd2, OPI);
      imem[2] = r_t(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
      do_reset();
      wait_done(200, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL alu_basic.timeout got done=0 want 1"); end
      n_cmp++; if (dut.regs[3] !== 32'd2) begin n_bad++; $display("FAIL alu_basic.x3 got %h want 2", dut.regs[3]); end
      n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL alu_basic.illegal got %b want 0", illegal); end
      n_cmp++; if (instr_cnt !== 32'd3) begin n_bad++; $display("FAIL alu_basic.instr_cnt got %0d want 3", instr_cnt); end
      n_cmp++; if (clock_count !== 32'd18) begin n_bad++; $display("FAIL alu_basic.cycles got %0d want 18", clock_count); end
      repeat (5) @(negedge clk);
      n_cmp++; if (clock_count !== 32'd18 || done !== 1'b1) begin n_bad++; $display("FAIL alu_basic.frozen got %0d/%b want 18/1", clock_count, done); end
   endtask

   task automatic test_alu_ops();
      bit ok;
      logic [31:0] exp [3:15];
      clear_imem();
      imem[0]  = i_t(12'd5, 5'd0, 3'b000, 5'd1, OPI);
      imem[1]  = i_t(12'hFFD, 5'd0, 3'b000, 5'd2, OPI);
      imem[2]  = r_t(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);   // add
      imem[3]  = r_t(7'h20, 5'd2, 5'd1, 3'b000, 5'd4);   // sub
      imem[4]  = r_t(7'h00, 5'd2, 5'd1, 3'b111, 5'd5);   // and
      imem[5]  = r_t(7'h00, 5'd2, 5'd1, 3'b110, 5'd6);   // or
      imem[6]  = r_t(7'h00, 5'd2, 5'd1, 3'b100, 5'd7);   // xor
      imem[7]  = r_t(7'h00, 5'd1, 5'd2, 3'b010, 5'd8);   // slt x2<x1
      imem[8]  = r_t(7'h00, 5'd1, 5'd1, 3'b001, 5'd9);   // sll
      imem[9]  = r_t(7'h00, 5'd1, 5'd2, 3'b101, 5'd10);  // srl
      imem[10] = r_t(7'h20, 5'd1, 5'd2, 3'b101, 5'd11);  // sra
      imem[11] = i_t(12'd15, 5'd2, 3'b111, 5'd12, OPI);  // andi
      imem[12] = i_t(12'd16, 5'd1, 3'b110, 5'd13, OPI);  // ori
      imem[13] = i_t(12'd0, 5'd2, 3'b010, 5'd14, OPI);   // slti
      imem[14] = u_t(7'b0010111, 5'd15, 20'h00001);      // auipc at 0x38
      exp[3] = 32'd2;          exp[4] = 32'd8;          exp[5] = 32'd5;
      exp[6] = 32'hFFFF_FFFD;  exp[7] = 32'hFFFF_FFF8;  exp[8] = 32'd1;
      exp[9] = 32'h0000_00A0;  exp[10] = 32'h07FF_FFFF; exp[11] = 32'hFFFF_FFFF;
      exp[12] = 32'hD;         exp[13] = 32'h15;        exp[14] = 32'd1;
      exp[15] = 32'h0000_1038;
      do_reset();
      wait_done(500, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL alu_ops.timeout got done=0 want 1"); end
      for (int r = 3; r <= 15; r++) begin
         n_cmp++; if (dut.regs[r] !== exp[r]) begin n_bad++; $display("FAIL alu_ops.x%0d got %h want %h", r, dut.regs[r], exp[r]); end
      end
      n_cmp++; if (instr_cnt !== 32'd15) begin n_bad++; $display("FAIL alu_ops.instr_cnt got %0d want 15", instr_cnt); end
      n_cmp++; if (clock_count !== 32'd78) begin n_bad++; $display("FAIL alu_ops.cycles got %0d want 78", clock_count); end
   endtask

   task automatic test_mem();
      bit ok;
      int base, lat;
      logic [31:0] v;
      for (int k = 0; k < 2; k++) begin
         lat = (k == 0) ? 4 : 0;
         v   = (k == 0) ? 32'd5 : 32'd9;
         clear_imem();
         imem[0] = i_t(v[11:0], 5'd0, 3'b000, 5'd1, OPI);
         imem[1] = s_t(12'd8, 5'd1, 5'd0);                       // sw x1,8(x0)
         imem[2] = i_t(12'd8, 5'd0, 3'b010, 5'd4, 7'b0000011);   // lw x4,8(x0)
         dmem_lat = lat;
         base = dq.size();
         do_reset();
         wait_done(300, ok);
         n_cmp++; if (!ok) begin n_bad++; $display("FAIL mem%0d.timeout got done=0 want 1", lat); end
         n_cmp++; if (dq.size() - base !== 2) begin n_bad++; $display("FAIL mem%0d.txn_count got %0d want 2", lat, dq.size() - base); end
         if (dq.size() - base >= 2) begin
            n_cmp++; if (dq[base].addr !== 14'd2 || dq[base].we !== 1'b1 || dq[base].wdata !== v)
               begin n_bad++; $display("FAIL mem%0d.store got a=%0d we=%b d=%h want a=2 we=1 d=%h", lat, dq[base].addr, dq[base].we, dq[base].wdata, v); end
            n_cmp++; if (dq[base].held !== lat + 1) begin n_bad++; $display("FAIL mem%0d.store_held got %0d want %0d", lat, dq[base].held, lat + 1); end
            n_cmp++; if (dq[base+1].addr !== 14'd2 || dq[base+1].we !== 1'b0)
               begin n_bad++; $display("FAIL mem%0d.load got a=%0d we=%b want a=2 we=0", lat, dq[base+1].addr, dq[base+1].we); end
            n_cmp++; if (dq[base+1].held !== lat + 1) begin n_bad++; $display("FAIL mem%0d.load_held got %0d want %0d", lat, dq[base+1].held, lat + 1); end
         end
         n_cmp++; if (drop_err !== 0) begin n_bad++; $display("FAIL mem%0d.req_dropped got %0d want 0", lat, drop_err); end
         n_cmp++; if (dut.regs[4] !== v) begin n_bad++; $display("FAIL mem%0d.x4 got %h want %h", lat, dut.regs[4], v); end
         n_cmp++; if (instr_cnt !== 32'd3) begin n_bad++; $display("FAIL mem%0d.instr_cnt got %0d want 3", lat, instr_cnt); end
      end
      dmem_lat = 0;
   endtask

   task automatic test_branch();
      bit ok;
      int base;
      int exp [8] = '{0, 1, 2, 4, 5, 6, 7, 9};
      clear_imem();
      imem[0] = i_t(12'd5, 5'd0, 3'b000, 5'd1, OPI);
      imem[1] = i_t(12'hFFD, 5'd0, 3'b000, 5'd2, OPI);
      imem[2] = b_t(3'b100, 5'd2, 5'd1, 12'd4);            // blt x2,x1,+8 (taken)
      imem[3] = i_t(12'd1, 5'd0, 3'b000, 5'd20, OPI);
      imem[4] = b_t(3'b001, 5'd1, 5'd1, 12'd4);            // bne x1,x1 (not taken)
      imem[5] = i_t(12'd9, 5'd0, 3'b000, 5'd21, OPI);
      imem[6] = b_t(3'b000, 5'd1, 5'd2, 12'd4);            // beq x1,x2 (not taken)
      imem[7] = b_t(3'b101, 5'd1, 5'd2, 12'd4);            // bge x1,x2 (taken)
      imem[8] = i_t(12'd1, 5'd0, 3'b000, 5'd22, OPI);
      base = fq.size();
      do_reset();
      wait_done(300, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL branch.timeout got done=0 want 1"); end
      n_cmp++; if (fq.size() - base !== 8) begin n_bad++; $display("FAIL branch.fetches got %0d want 8", fq.size() - base); end
      if (fq.size() - base >= 8)
         for (int i = 0; i < 8; i++) begin
            n_cmp++; if (fq[base+i] !== 10'(exp[i])) begin n_bad++; $display("FAIL branch.fetch%0d got %0d want %0d", i, fq[base+i], exp[i]); end
         end
      n_cmp++; if ({dut.regs[20], dut.regs[21], dut.regs[22]} !== {32'd0, 32'd9, 32'd0})
         begin n_bad++; $display("FAIL branch.regs got %h/%h/%h want 0/9/0", dut.regs[20], dut.regs[21], dut.regs[22]); end
      n_cmp++; if (instr_cnt !== 32'd7) begin n_bad++; $display("FAIL branch.instr_cnt got %0d want 7", instr_cnt); end
   endtask

   task automatic test_jal();
      bit ok;
      int base;
      int exp [8] = '{0, 1, 2, 3, 4, 7, 8, 10};
      clear_imem();
      imem[0] = i_t(12'd5, 5'd0, 3'b000, 5'd1, OPI);
      for (int i = 1; i <= 3; i++) imem[i] = i_t(12'd0, 5'd0, 3'b000, 5'd0, OPI);
      imem[4] = j_t(5'd5, 20'd6);                                 // jal x5,+12 at 0x10
      imem[5] = i_t(12'd1, 5'd0, 3'b000, 5'd23, OPI);
      imem[6] = i_t(12'd1, 5'd0, 3'b000, 5'd23, OPI);
      imem[7] = u_t(7'b0110111, 5'd6, 20'h12345);                 // lui x6
      imem[8] = i_t(12'd21, 5'd5, 3'b000, 5'd7, 7'b1100111);      // jalr x7,21(x5)
      imem[9] = i_t(12'd1, 5'd0, 3'b000, 5'd24, OPI);
      base = fq.size();
      do_reset();
      wait_done(300, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL jal.timeout got done=0 want 1"); end
      n_cmp++; if (dut.regs[5] !== 32'h14) begin n_bad++; $display("FAIL jal.x5 got %h want 14", dut.regs[5]); end
      n_cmp++; if (dut.regs[6] !== 32'h1234_5000) begin n_bad++; $display("FAIL jal.lui_x6 got %h want 12345000", dut.regs[6]); end
      n_cmp++; if (dut.regs[7] !== 32'h24) begin n_bad++; $display("FAIL jal.jalr_x7 got %h want 24", dut.regs[7]); end
      n_cmp++; if (dut.regs[23] !== 32'd0 || dut.regs[24] !== 32'd0) begin n_bad++; $display("FAIL jal.skipped got %h/%h want 0/0", dut.regs[23], dut.regs[24]); end
      n_cmp++; if (fq.size() - base !== 8) begin n_bad++; $display("FAIL jal.fetches got %0d want 8", fq.size() - base); end
      if (fq.size() - base >= 8)
         for (int i = 0; i < 8; i++) begin
            n_cmp++; if (fq[base+i] !== 10'(exp[i])) begin n_bad++; $display("FAIL jal.fetch%0d got %0d want %0d", i, fq[base+i], exp[i]); end
         end
      n_cmp++; if (instr_cnt !== 32'd7) begin n_bad++; $display("FAIL jal.instr_cnt got %0d want 7", instr_cnt); end
   endtask

   task automatic test_illegal();
      bit ok;
      clear_imem();
      imem[0] = i_t(12'd5, 5'd0, 3'b000, 5'd1, OPI);
      imem[1] = 32'h0000_0073;                     // opcode 1110011
      do_reset();
      wait_done(100, ok);
      n_cmp++; if (!ok || illegal !== 1'b1) begin n_bad++; $display("FAIL illegal.op got done=%b illegal=%b want 1/1", done, illegal); end
      n_cmp++; if (instr_cnt !== 32'd1) begin n_bad++; $display("FAIL illegal.instr_cnt got %0d want 1", instr_cnt); end
      repeat (10) @(negedge clk);
      n_cmp++; if (clock_count !== 32'd9) begin n_bad++; $display("FAIL illegal.cycles_frozen got %0d want 9", clock_count); end
      // unsupported funct3 on OP-IMM (slli)
      imem[1] = i_t(12'd1, 5'd1, 3'b001, 5'd2, OPI);
      do_reset();
      wait_done(100, ok);
      n_cmp++; if (!ok || illegal !== 1'b1 || dut.regs[2] !== 32'd0)
         begin n_bad++; $display("FAIL illegal.funct got illegal=%b x2=%h want 1/0", illegal, dut.regs[2]); end
   endtask

   task automatic test_mul();
      bit ok;
      clear_imem();
      imem[0] = i_t(12'd5, 5'd0, 3'b000, 5'd1, OPI);
      imem[1] = r_t(7'h01, 5'd1, 5'd1, 3'b000, 5'd7);
      do_reset();
      wait_done(100, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL mul.timeout got done=0 want 1"); end
`ifdef RV_MUL_EN
      n_cmp++; if (dut.regs[7] !== 32'd25 || illegal !== 1'b0) begin n_bad++; $display("FAIL mul.x7 got %h/%b want 19/0", dut.regs[7], illegal); end
      n_cmp++; if (instr_cnt !== 32'd2) begin n_bad++; $display("FAIL mul.instr_cnt got %0d want 2", instr_cnt); end
`else
      n_cmp++; if (illegal !== 1'b1 || dut.regs[7] !== 32'd0) begin n_bad++; $display("FAIL mul.illegal got %b/%h want 1/0", illegal, dut.regs[7]); end
      n_cmp++; if (instr_cnt !== 32'd1) begin n_bad++; $display("FAIL mul.instr_cnt got %0d want 1", instr_cnt); end
`endif
   endtask

   task automatic test_reset_fwait();
      bit ok;
      logic [31:0] i0;
      clear_imem();
      i0 = i_t(12'd5, 5'd0, 3'b000, 5'd1, OPI);
      imem[0] = i0;
      imem[1] = i_t(12'd7, 5'd0, 3'b000, 5'd2, OPI);
      force_data = i_t(12'd99, 5'd0, 3'b000, 5'd9, OPI);
      do_reset();
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (instr_cnt == 32'd1) begin ok = 1'b1; break; end
      end
      imem_lat = 100;                       // stall the second fetch in FWAIT
      @(negedge clk);
      n_cmp++; if (!ok || imem_req !== 1'b1 || dut.regs[1] !== 32'd5)
         begin n_bad++; $display("FAIL rstfw.setup got ok=%b req=%b x1=%h want 1/1/5", ok, imem_req, dut.regs[1]); end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (imem_req !== 1'b0 || dut.pc !== 32'h0) begin n_bad++; $display("FAIL rstfw.after_rst got req=%b pc=%h want 0/0", imem_req, dut.pc); end
      n_cmp++; if (dut.regs[1] !== 32'd0 || instr_cnt !== 32'd0 || clock_count !== 32'd0)
         begin n_bad++; $display("FAIL rstfw.cleared got x1=%h ic=%0d cc=%0d want 0/0/0", dut.regs[1], instr_cnt, clock_count); end
      rst = 1'b0; force_rv = 1'b1;          // late response from the aborted fetch
      @(negedge clk);
      force_rv = 1'b0;
      n_cmp++; if (dut.ir !== i0) begin n_bad++; $display("FAIL rstfw.ir_stale got %h want %h", dut.ir, i0); end
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 10'd0 || dut.pc !== 32'h0)
         begin n_bad++; $display("FAIL rstfw.refetch got req=%b addr=%0d pc=%h want 1/0/0", imem_req, imem_addr, dut.pc); end
      imem_lat = 0;
      wait_done(100, ok);
      n_cmp++; if (!ok || dut.regs[1] !== 32'd5 || dut.regs[2] !== 32'd7 || instr_cnt !== 32'd2)
         begin n_bad++; $display("FAIL rstfw.rerun got x1=%h x2=%h ic=%0d want 5/7/2", dut.regs[1], dut.regs[2], instr_cnt); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired got running want finished");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; force_rv = 1'b0; force_data = '0;
      imem_lat = 0; dmem_lat = 0;
      test_reset();
      test_alu_basic();
      test_alu_ops();
      test_mem();
      test_branch();
      test_jal();
      test_illegal();
      test_mul();
      test_reset_fwait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/riscv_multi_hs.md
Name: riscv_multi_hs

Overview:
- Next-generation multicycle RV32 integer core. Replaces fixed-latency on-chip instruction/data RAM reads with valid/ready memory request ports, so the memories may have any latency.
- Widens the instruction subset and parametrises address widths and reset PC.
- Sits between the board top (CLOCK_50, rst) and external instruction/data memory blocks.
- Reports completion, cycle count and retired-instruction count.

Parameters:
- RESET_PC, 32'h0, PC value loaded on reset.
- IADDR_W, 10, instruction word-address width; imem_addr = PC[IADDR_W+1:2].
- DADDR_W, 14, data word-address width; dmem_addr = effective_addr[DADDR_W+1:2].
- EOF_WORD, 32'hFFFF_FFFF, instruction word that halts the core.

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction fetch request valid.
- imem_addr  out  IADDR_W  instruction word address.
- imem_rvalid  in  1  instruction read data valid.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data request valid.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req is high.
- dmem_addr  out  DADDR_W  data word address.
- dmem_wdata  out  32  store data.
- dmem_ack  in  1  data access complete; for loads, dmem_rdata is valid in the same cycle.
- dmem_rdata  in  32  load data.
- done  out  1  high while halted.
- illegal  out  1  high while halted on an unsupported instruction.
- clock_count  out  32  cycles since reset; stops counting once halted.
- instr_cnt  out  32  retired instructions.

Behaviour:
- Reset (synchronous): state=FETCH, PC=RESET_PC, all 32 registers=0, clock_count=0, instr_cnt=0, done=0, illegal=0, imem_req=0, dmem_req=0, dmem_we=0.
- States: FETCH, FWAIT, DECODE, EXEC, MEM, WB, HALT.
- FETCH: assert imem_req with imem_addr; go to FWAIT.
- FWAIT: imem_req stays high until imem_rvalid. On imem_rvalid: IR<=imem_rdata, PC<=PC+4, imem_req<=0, go to DECODE.
- DECODE:
  - IR==EOF_WORD -> HALT with done=1.
  - Otherwise read rs1/rs2, latch the immediate (I/S/B/U/J formats, sign-extended), go to EXEC.
- EXEC, by instruction:
  - add/sub/and/or/xor/slt/sll/srl/sra: result to ALUOut -> WB.
  - addi/andi/ori/slti: result to ALUOut -> WB.
  - lw/sw: address=rs1+imm -> MEM.
  - beq/bne/blt/bge: signed compare; taken -> PC<=oldPC+imm -> FETCH.
  - jal: rd<=PC, PC<=oldPC+imm -> FETCH.
  - jalr: rd<=PC, PC<=(rs1+imm)&~1 -> FETCH.
  - lui: ALUOut=imm -> WB.
  - auipc: ALUOut=oldPC+imm -> WB.
  - oldPC is the instruction's own address (PC-4).
- Unsupported opcode or funct -> HALT with done=1, illegal=1. That instruction is not counted.
- MEM:
  - dmem_req held high, address/data/we stable, until dmem_ack.
  - Load: on ack, MDR<=dmem_rdata -> WB.
  - Store: on ack, dmem_req drops -> FETCH.
  - Address bits [1:0] are ignored (no misalignment trap).
- WB: rd<=ALUOut or MDR -> FETCH.
- instr_cnt increments by 1 at the cycle the instruction completes (WB, store ack, branch/jump in EXEC).
- Writes to x0 are discarded; x0 always reads 0.
- HALT: terminal; only rst leaves it.
- Arithmetic wraps modulo 2^32. Shift amount uses rs2[4:0] or imm[4:0].
- Reset mid-request: requests drop in the same cycle that reset is sampled. Any late imem_rvalid or dmem_ack is ignored unless the core is in FWAIT or MEM.
- dmem_ack in the same cycle the request is first asserted is legal (single-cycle memory).

Optional Feature:
- RV_MUL_EN defined: mul (funct7=0000001, funct3=000) is supported, low 32 bits of the product, EXEC->WB.
- Without it: mul is illegal -> HALT with illegal=1, and no multiplier is inferred.

Test Plan:
- addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; EOF, zero-latency memories -> x3=2, done=1, instr_cnt=3, illegal=0.
- sw x1,8(x0) then lw x4,8(x0), dmem_ack delayed 4 cycles -> dmem_addr=2, dmem_wdata=5, x4=5; dmem_req held high for the full wait each time.
- blt x2,x1,+8 with x2=-3, x1=5 -> next fetch address is oldPC+8. Same test with bne on equal operands -> falls through to PC+4.
- jal x5,+12 at PC 0x10 -> x5=0x14, next imem_addr=0x1C>>2. lui x6,0x12345 -> x6=0x12345000.
- Unsupported opcode 7'b1110011 -> done=1, illegal=1, clock_count frozen. mul x7,x1,x1: with RV_MUL_EN x7=25; without it illegal=1.
- rst asserted while in FWAIT with imem_rvalid pulsing in the next cycle -> state=FETCH, PC=RESET_PC, registers=0, IR not updated from the stale data.
